// File: rtl/usr_pkg.sv
// ============================================================================
// Module  : usr_pkg
// Brief   : Shared op codes, sequencer states and widths for the universal
//           shift register and its command sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

  localparam int USR_REG_W = 6;
  localparam int USR_LEN_W = 6;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_SHL    = 3'b001,
    OP_SHR    = 3'b010,
    OP_CLR    = 3'b011,
    OP_PRESET = 3'b100,
    OP_UP     = 3'b101,
    OP_DOWN   = 3'b110,
    OP_LOAD   = 3'b111
  } usr_op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_seq_state_t;

  // Ops whose repeat count is meaningless: repeating them changes nothing.
  function automatic logic usr_is_single_shot(input usr_op_t op);
    return (op == OP_CLR) || (op == OP_PRESET) || (op == OP_LOAD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usr_sequencer.sv
// ============================================================================
// Module  : usr_sequencer
// Brief   : Valid/ready command sequencer driving A/D/RSI/LSI of the 6-bit
//           universal shift register for a programmed number of cycles.
//           Optional macro USR_SEQ_SAT_EN stops Up/Down at the count limits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_sequencer
  import usr_pkg::*;
#(
  parameter int REG_W = USR_REG_W,
  parameter int LEN_W = USR_LEN_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [REG_W-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [REG_W-1:0] q_in,
  output logic [2:0]       A,
  output logic [REG_W-1:0] D,
  output logic             RSI,
  output logic             LSI,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  usr_seq_state_t   r_state;
  usr_seq_state_t   w_state_nxt;
  usr_op_t          r_op;
  usr_op_t          w_op;
  logic [LEN_W-1:0] r_remain;
  logic [REG_W-1:0] r_d;
  logic             r_rsi;
  logic             r_lsi;
  logic             r_done;
  logic             r_sat;
  logic             w_last;
  logic             w_accept;
  logic             w_sat_hit;

  assign w_op = usr_op_t'(cmd_op);

`ifdef USR_SEQ_SAT_EN
  assign w_sat_hit = (r_state == ST_RUN) &&
                     (((r_op == OP_UP)   && (&q_in)) ||
                      ((r_op == OP_DOWN) && ~(|q_in)));
`else
  logic w_unused_q;
  assign w_unused_q = ^q_in;
  assign w_sat_hit  = 1'b0;
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    cmd_ready   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RUN: begin
        w_last    = (r_remain == '0) || w_sat_hit;
        cmd_ready = w_last;
      end
      default: ;
    endcase
    w_accept = cmd_valid && cmd_ready;
    // A command taken in the last cycle chains straight into the next RUN.
    if (w_accept) begin
      w_state_nxt = ST_RUN;
    end else if (w_last) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OP_HOLD;
      r_remain <= '0;
      r_d      <= '0;
      r_rsi    <= 1'b0;
      r_lsi    <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_done <= w_last;
      r_sat  <= w_last && w_sat_hit;
      if (w_accept) begin
        r_op     <= w_op;
        r_d      <= (w_op == OP_LOAD) ? cmd_data : '0;
        r_rsi    <= (w_op == OP_SHL) && cmd_fill;
        r_lsi    <= (w_op == OP_SHR) && cmd_fill;
        r_remain <= usr_is_single_shot(w_op) ? '0 : cmd_len;
      end else if (w_last) begin
        r_op     <= OP_HOLD;
        r_d      <= '0;
        r_rsi    <= 1'b0;
        r_lsi    <= 1'b0;
        r_remain <= '0;
      end else if (r_state == ST_RUN) begin
        r_remain <= r_remain - LEN_W'(1);
      end
    end
  end

  // The saturation gate bypasses the register so the limit value is never passed.
  assign A    = w_sat_hit ? OP_HOLD : r_op;
  assign D    = r_d;
  assign RSI  = r_rsi;
  assign LSI  = r_lsi;
  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign sat  = r_sat;

endmodule

`default_nettype wire
